// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package mod_updown_counter_pkg;

    // Common digit configurations.
    localparam int BCD_WIDTH    = 4;
    localparam int BCD_MODULUS  = 10;
    localparam int MOD6_WIDTH   = 3;
    localparam int MOD6_MODULUS = 6;

    // What the counter does at a given edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_RESET = 2'd3
    } op_e;

    // Terminal-value compare. Operands are widened to 32 bits so one helper
    // serves every digit width.
    function automatic logic digit_is(input logic [31:0] q, input logic [31:0] term);
        return q == term;
    endfunction

    // A load digit is usable only when it is strictly below the modulus.
    function automatic logic digit_in_range(input logic [31:0] d, input logic [31:0] modulus);
        return d < modulus;
    endfunction

endpackage

// File: rtl/mod_counter_digit.sv
// One modulo-MODULUS digit: synchronous reset, load, and single up/down step.
module mod_counter_digit
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             step,
    input  logic             ud,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    // Digit register: reset beats load beats step; wraps stay inside 0..MODULUS-1.
    always_ff @(posedge CP) begin
        if (CR) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (step) begin
            if (ud) begin
                q <= (q == MAXV) ? '0 : q + WIDTH'(1);
            end else begin
                q <= (q == '0) ? MAXV : q - WIDTH'(1);
            end
        end
    end

    // Terminal flags feed the cascade prefix in the parent.
    always_comb begin
        at_max  = digit_is(32'(q), 32'(MODULUS - 1));
        at_zero = digit_is(32'(q), 32'd0);
    end

endmodule

// File: rtl/mod_updown_counter.sv
// DIGITS-digit synchronous up/down counter with load range check, cascade
// outputs and a registered whole-counter wrap pulse.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH   = BCD_WIDTH,
    parameter int MODULUS = BCD_MODULUS,
    parameter int DIGITS  = 2
) (
    input  logic                    CP,
    input  logic                    CR,
    input  logic                    LD,
    input  logic                    CTp,
    input  logic                    CTt,
    input  logic                    UD,
    input  logic [DIGITS*WIDTH-1:0] D,
    output logic [DIGITS*WIDTH-1:0] Q,
    output logic                    CO,
    output logic                    BO,
    output logic                    WRAP,
    output logic                    ERR
);

    op_e               op;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] bad;
    logic [DIGITS:0]   up_pre;
    logic [DIGITS:0]   dn_pre;
    logic              count_en;
    logic              wrap_now;

    // Edge operation decode, reset first, then active-low load, then count.
    always_comb begin
        op = OP_HOLD;
        if (CR)              op = OP_RESET;
        else if (!LD)        op = OP_LOAD;
        else if (CTp && CTt) op = OP_COUNT;
    end

    assign count_en = (op == OP_COUNT);

    // AND-prefix of terminal flags: bit k is set when every digit below k is
    // at its terminal value, so all digits step on the same edge.
    always_comb begin
        up_pre    = '0;
        dn_pre    = '0;
        up_pre[0] = 1'b1;
        dn_pre[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            up_pre[k+1] = up_pre[k] & at_max[k];
            dn_pre[k+1] = dn_pre[k] & at_zero[k];
        end
    end

    // Per-digit step enables, load sanitising and the digit instances.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [WIDTH-1:0] d_dig;
        logic             d_ok;

        assign d_dig   = D[i*WIDTH +: WIDTH];
        assign d_ok    = digit_in_range(32'(d_dig), 32'(MODULUS));
        assign bad[i]  = ~d_ok;
        assign step[i] = count_en & (UD ? up_pre[i] : dn_pre[i]);

        mod_counter_digit #(
            .WIDTH   (WIDTH),
            .MODULUS (MODULUS)
        ) u_dig (
            .CP      (CP),
            .CR      (CR),
            .ld      (op == OP_LOAD),
            .ld_val  (d_ok ? d_dig : '0),
            .step    (step[i]),
            .ud      (UD),
            .q       (Q[i*WIDTH +: WIDTH]),
            .at_max  (at_max[i]),
            .at_zero (at_zero[i])
        );
    end

    // The whole counter wraps when every digit is terminal in the count direction.
    assign wrap_now = count_en & (UD ? up_pre[DIGITS] : dn_pre[DIGITS]);

    // Cascade outputs are combinational so chained instances see them in the same cycle.
    assign CO = CTt &  UD & up_pre[DIGITS];
    assign BO = CTt & ~UD & dn_pre[DIGITS];

    // WRAP pulses for one cycle after a wrapping count; ERR only moves on reset/load.
    always_ff @(posedge CP) begin
        case (op)
            OP_RESET: begin
                WRAP <= 1'b0;
                ERR  <= 1'b0;
            end
            OP_LOAD: begin
                WRAP <= 1'b0;
                ERR  <= |bad;
            end
            OP_COUNT: begin
                WRAP <= wrap_now;
            end
            default: begin
                WRAP <= 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: integer-value reference model for the BCD instance,
// directed test-plan pins, randomized traffic, and a parameter sweep.
module tb_mod_updown_counter;

    localparam int W  = 4;
    localparam int M  = 10;
    localparam int DG = 2;
    localparam int N  = 100;  // M**DG

    logic          CP = 1'b0;
    logic          CR, LD, CTp, CTt, UD;
    logic [DG*W-1:0] D;
    logic [DG*W-1:0] Q;
    logic          CO, BO, WRAP, ERR;

    // Sweep instances.
    logic          sw_cr, sw_en;
    logic [11:0]   q16;
    logic          co16, bo16, wrap16, err16;
    logic [2:0]    q6;
    logic          co6, bo6, wrap6, err6;
    int            w16_cnt, w6_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    // Model state: the counter as a single integer in 0..N-1.
    int   m_v;
    logic m_wrap, m_err;

    always #5 CP = ~CP;

    mod_updown_counter #(.WIDTH(W), .MODULUS(M), .DIGITS(DG)) dut (
        .CP(CP), .CR(CR), .LD(LD), .CTp(CTp), .CTt(CTt), .UD(UD), .D(D),
        .Q(Q), .CO(CO), .BO(BO), .WRAP(WRAP), .ERR(ERR)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .DIGITS(3)) u16 (
        .CP(CP), .CR(sw_cr), .LD(1'b1), .CTp(sw_en), .CTt(sw_en), .UD(1'b1), .D(12'h000),
        .Q(q16), .CO(co16), .BO(bo16), .WRAP(wrap16), .ERR(err16)
    );

    mod_updown_counter #(.WIDTH(3), .MODULUS(6), .DIGITS(1)) u6 (
        .CP(CP), .CR(sw_cr), .LD(1'b1), .CTp(sw_en), .CTt(sw_en), .UD(1'b1), .D(3'd0),
        .Q(q6), .CO(co6), .BO(bo6), .WRAP(wrap6), .ERR(err6)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DG*W-1:0] pack(input int v);
        logic [DG*W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DG; i++) begin
            r[i*W +: W] = W'((v / p) % M);
            p = p * M;
        end
        return r;
    endfunction

    // Reference model: counting is plain modular arithmetic on the whole value.
    always @(posedge CP) begin
        if (CR === 1'b1) begin
            m_v = 0; m_wrap = 1'b0; m_err = 1'b0;
        end else if (LD === 1'b0) begin
            int p; int dd;
            m_v = 0; m_err = 1'b0; p = 1;
            for (int i = 0; i < DG; i++) begin
                dd = int'(D[i*W +: W]);
                if (dd < M) m_v = m_v + dd * p;
                else m_err = 1'b1;
                p = p * M;
            end
            m_wrap = 1'b0;
        end else if (CTp && CTt) begin
            if (UD) begin
                m_wrap = (m_v == N - 1);
                m_v = (m_v + 1) % N;
            end else begin
                m_wrap = (m_v == 0);
                m_v = (m_v + N - 1) % N;
            end
        end else begin
            m_wrap = 1'b0;
        end
    end

    // Compare process: every cycle once the counter has been reset.
    always @(negedge CP) begin
        if (chk_en) begin
            chk("q",    32'(Q),    32'(pack(m_v)));
            chk("wrap", 32'(WRAP), 32'(m_wrap));
            chk("err",  32'(ERR),  32'(m_err));
            chk("co",   32'(CO),   32'(CTt & UD & (m_v == N - 1)));
            chk("bo",   32'(BO),   32'(CTt & ~UD & (m_v == 0)));
        end
    end

    // Sweep wrap-pulse counters.
    always @(negedge CP) begin
        if (sw_en) begin
            if (wrap16) w16_cnt++;
            if (wrap6)  w6_cnt++;
        end
    end

    // Apply inputs, let one rising edge pass, return shortly after the falling edge.
    task automatic step(input logic cr, input logic ld, input logic ctp, input logic ctt,
                        input logic ud, input logic [DG*W-1:0] d);
        CR = cr; LD = ld; CTp = ctp; CTt = ctt; UD = ud; D = d;
        @(negedge CP);
        #2;
    endtask

    initial begin
        logic ud_r;
        sw_cr = 1'b1; sw_en = 1'b0; w16_cnt = 0; w6_cnt = 0;

        // Reset state.
        step(1, 1, 0, 0, 1, 8'h00);
        chk_en = 1'b1;
        chk("rst_q",    32'(Q),    32'h00);
        chk("rst_wrap", 32'(WRAP), 32'h0);
        chk("rst_err",  32'(ERR),  32'h0);

        // Count up through 00..99 and wrap.
        repeat (99) step(0, 1, 1, 1, 1, 8'h00);
        chk("up99_q",  32'(Q),  32'h99);
        chk("up99_co", 32'(CO), 32'h1);
        step(0, 1, 1, 1, 1, 8'h00);
        chk("upwrap_q",    32'(Q),    32'h00);
        chk("upwrap_wrap", 32'(WRAP), 32'h1);
        chk("upwrap_co",   32'(CO),   32'h0);
        step(0, 1, 0, 1, 1, 8'h00);
        chk("wrap_1cyc", 32'(WRAP), 32'h0);

        // Load 00 and count down once.
        step(0, 0, 1, 1, 0, 8'h00);
        step(0, 1, 1, 1, 0, 8'h00);
        chk("dn_q",    32'(Q),    32'h99);
        chk("dn_wrap", 32'(WRAP), 32'h1);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 1, 0, 8'h00);
        chk("bo_at0", 32'(BO), 32'h1);

        // Load with range check, then count keeps ERR.
        step(0, 0, 1, 1, 1, 8'h57);
        chk("ld57_q",   32'(Q),   32'h57);
        chk("ld57_err", 32'(ERR), 32'h0);
        step(0, 0, 1, 1, 1, 8'h5C);
        chk("ld5c_q",   32'(Q),   32'h50);
        chk("ld5c_err", 32'(ERR), 32'h1);
        repeat (3) step(0, 1, 1, 1, 1, 8'h00);
        chk("cnt3_q",   32'(Q),   32'h53);
        chk("cnt3_err", 32'(ERR), 32'h1);

        // Hold with CTp low keeps CO; dropping CTt kills CO.
        step(0, 0, 0, 0, 1, 8'h99);
        step(0, 1, 0, 1, 1, 8'h00);
        chk("hold_q",  32'(Q),  32'h99);
        chk("hold_co", 32'(CO), 32'h1);
        step(0, 1, 1, 0, 1, 8'h00);
        chk("ctt0_q",  32'(Q),  32'h99);
        chk("ctt0_co", 32'(CO), 32'h0);

        // Reset wins over a simultaneous load mid-count.
        step(0, 0, 1, 1, 1, 8'h4F);
        repeat (2) step(0, 1, 1, 1, 1, 8'h00);
        chk("pre_rst_q",   32'(Q),   32'h42);
        chk("pre_rst_err", 32'(ERR), 32'h1);
        step(1, 0, 1, 1, 1, 8'h77);
        chk("rstld_q",    32'(Q),    32'h00);
        chk("rstld_err",  32'(ERR),  32'h0);
        chk("rstld_wrap", 32'(WRAP), 32'h0);

        // Randomized traffic against the model.
        ud_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) ud_r = ~ud_r;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                 ud_r, 8'($urandom_range(0, 255)));
        end
        step(0, 1, 0, 0, 1, 8'h00);

        // Parameter sweep: mod-16 x3 and mod-6 x1 counting up from reset.
        sw_cr = 1'b1; sw_en = 1'b0;
        @(negedge CP); #2;
        sw_cr = 1'b0; sw_en = 1'b1;
        repeat (6) begin @(negedge CP); #2; end
        chk("m6_q6",    32'(q6),     32'h0);
        chk("m6_wraps", 32'(w6_cnt), 32'd1);
        chk("m16_q6",   32'(q16),    32'h006);
        repeat (4089) begin @(negedge CP); #2; end
        chk("m16_qfff", 32'(q16), 32'hFFF);
        chk("m16_co",   32'(co16), 32'h1);
        @(negedge CP); #2;
        chk("m16_q0",     32'(q16),     32'h000);
        chk("m16_wraps",  32'(w16_cnt), 32'd1);
        chk("m6_q4096",   32'(q6),      32'h4);
        chk("m6_wraps_n", 32'(w6_cnt),  32'd682);
        sw_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
